debug_reply_tx: RTL and testbench
=================================

# debug_reply_tx

Serializing transmitter for the debug unit's replies to the host client. It queues the two client-bound packets: `OP_OK` (0x02, answer to `OP_PING`) and `OP_SIGNAL` (0x01 followed by PC and signal bytes). It emits them as 8N1 UART frames on `uart_tx`. It is the transmit-side counterpart of the debug command receiver: same baud, same framing, same little-endian multi-byte order.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200).
- `SIG_BYTES`, default 4: number of signal bytes following the PC in `OP_SIGNAL`; range 1..16.
- `clk`  in  1: system clock. One clock domain; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `send_ok`  in  1: one-cycle request to queue an `OP_OK` packet.
- `send_signal`  in  1: one-cycle request to queue an `OP_SIGNAL` packet.
- `pc`  in  32: PC value, sampled at `OP_SIGNAL` packet start.
- `signals`  in  8*SIG_BYTES: signal bytes, sampled at `OP_SIGNAL` packet start; byte 0 is `signals[7:0]`.
- `busy`  out  1: high while a packet is on the line.
- `done`  out  1: one-cycle pulse at the end of a packet's last stop bit.
- `uart_tx`  out  1: serial line, idle high.

## Operation
- **Pending flags.** `ok_pend` and `sig_pend` are set by their request input in any state, including while busy.
  - A request for an already-pending type coalesces: one packet is sent.
  - A flag clears in the cycle its packet starts.
- **Arbitration.** From IDLE with any flag set, start a packet the next edge. If both flags are set, send `OP_OK` first. `OP_SIGNAL` follows directly after that packet's `done` cycle.
- **Packet contents.**
  - `OP_OK`: 1 byte, 0x02.
  - `OP_SIGNAL`: 5+SIG_BYTES bytes, in order: 0x01, `pc[7:0]`, `pc[15:8]`, `pc[23:16]`, `pc[31:24]`, `signals` byte 0 .. SIG_BYTES-1.
  - `pc` and `signals` are captured into a shadow register in the start cycle. Later input changes do not affect the packet in flight.
- **Bit FSM.** IDLE → START → DATA → STOP.
  - START drives 0.
  - DATA drives the byte LSB first, 8 bits.
  - STOP drives 1.
  - After STOP, if bytes remain in the packet, go to START with no idle gap. Otherwise signal `done` and return to IDLE.
- **Counters.**
  - Baud counter: 0..CLK_PER_BIT-1, wraps, restarts at each state entry.
  - Bit index: 0..7.
  - Byte index: 0..4+SIG_BYTES, sized ceil(log2(21)) = 5 bits.
- **Reset.** Asserting `rst` mid-frame aborts immediately and clears both pending flags. The line returns high, i.e. a truncated frame; this is acceptable.
- Requests arriving in the same cycle as `rst` are discarded.

## Timing
- **Reset values:** `uart_tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0, both pending flags 0.
- All outputs are registered; no combinational path from inputs to outputs.
- **Start latency from IDLE.** Request sampled at edge k sets its flag. At edge k+1 the packet starts: `uart_tx`=0 and `busy`=1.
- **Bit duration.** Each bit, including start and stop, holds exactly CLK_PER_BIT cycles. A byte takes 10*CLK_PER_BIT cycles.
- **Packet duration.** `OP_OK` takes 10*CLK_PER_BIT cycles. `OP_SIGNAL` takes 10*(5+SIG_BYTES)*CLK_PER_BIT cycles.
- **End of packet.**
  - `done`=1 and `busy`=0 in the cycle after the last stop bit's final cycle.
  - `uart_tx` stays 1.
  - If a flag is pending, the next packet's start bit begins on the following edge, giving one idle-high cycle between packets.
- **Simultaneous requests.** `send_ok` and `send_signal` in the same cycle: OK packet, one idle cycle, then SIGNAL packet.
- A request arriving in the `done` cycle is honored per the arbitration rules above.

## Test plan
- **Reset state.** Check the reset values with CLK_PER_BIT=4. Then drive `send_ok` at cycle 10.
  - `uart_tx` low at cycle 11 for 4 cycles.
  - Data bits 0,1,0,0,0,0,0,0 at 4 cycles each, then stop high.
  - `done` pulses at cycle 51; `busy` is high for exactly 40 cycles.
- **OP_SIGNAL contents.** With SIG_BYTES=4, drive `send_signal` with `pc`=0x000000DC and `signals`=0xA55A0FF0.
  - Decoded byte stream: 01 DC 00 00 00 F0 0F 5A A5.
  - No gap between frames; total 360 cycles.
- **Snapshot.** Change `pc` to 0xFFFFFFFF two cycles after start. The transmitted PC bytes remain DC 00 00 00.
- **Simultaneous requests.** `send_ok` and `send_signal` in the same cycle.
  - Stream: 02, one idle cycle, then the 9-byte signal packet.
  - Exactly two `done` pulses.
- **Coalescing.** Three `send_signal` pulses during an active OK packet. Exactly one SIGNAL packet follows.
- **Reset mid-frame.** Assert `rst` during a data bit.
  - `uart_tx`=1 and `busy`=0 immediately, asynchronously.
  - After release, the line stays idle and no pending packet is sent.

Source files
------------

// File: rtl/debug_reply_tx_if.sv
// Host-side bundle for the debug reply transmitter: packet requests with their
// payload, plus the transmitter status and serial line coming back.
interface debug_reply_tx_if #(
   parameter int SIG_BYTES = 4
);
   logic                   send_ok;
   logic                   send_signal;
   logic [31:0]            pc;
   logic [8*SIG_BYTES-1:0] signals;
   logic                   busy;
   logic                   done;
   logic                   uart_tx;

   // Requester side: raises packet requests and supplies PC/signal payload.
   modport master (
      output send_ok, send_signal, pc, signals,
      input  busy, done, uart_tx
   );

   // Transmitter side: consumes requests, reports status, drives the line.
   modport slave (
      input  send_ok, send_signal, pc, signals,
      output busy, done, uart_tx
   );
endinterface

// File: rtl/debug_reply_tx.sv
// Debug reply transmitter: queues OP_OK / OP_SIGNAL packets and sends them as
// back-to-back 8N1 UART frames, multi-byte fields little-endian.
module debug_reply_tx #(
   parameter int CLK_PER_BIT = 868,
   parameter int SIG_BYTES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   debug_reply_tx_if.slave  bus
);

   localparam int PKT_BYTES = 5 + SIG_BYTES;
   localparam int SW        = 8 * PKT_BYTES;
   localparam int CW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

   localparam logic [7:0]    OP_SIGNAL = 8'h01;
   localparam logic [7:0]    OP_OK     = 8'h02;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [4:0]    SIG_LAST  = 5'(PKT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [4:0]      byte_idx;
   logic [4:0]      last_idx;
   // Packet shadow, shifted right one bit per data bit so the bit on the line
   // next is always shadow[0] and the next byte lands in shadow[7:0].
   logic [SW-1:0]   shadow;
   logic            ok_pend;
   logic            sig_pend;
   logic            tx_q;
   logic            busy_q;
   logic            done_q;

   logic            baud_last;

   assign baud_last   = (baud_cnt == BAUD_LAST);

   assign bus.uart_tx = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

   // Packet arbitration, bit/byte sequencing and registered line outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         last_idx <= '0;
         shadow   <= '0;
         ok_pend  <= 1'b0;
         sig_pend <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only; every right-hand side below sees
         // the pre-edge register values, so statement order cannot leak state.
         done_q <= 1'b0;

         case (state)
            IDLE: begin
               if (ok_pend || sig_pend) begin
                  state    <= START;
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  byte_idx <= '0;
                  // OK wins a tie; a pending SIGNAL simply waits one packet.
                  if (ok_pend) begin
                     ok_pend  <= 1'b0;
                     shadow   <= {{(SW-8){1'b0}}, OP_OK};
                     last_idx <= '0;
                  end else begin
                     sig_pend <= 1'b0;
                     shadow   <= {bus.signals, bus.pc, OP_SIGNAL};
                     last_idx <= SIG_LAST;
                  end
               end
            end

            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= DATA;
                  tx_q     <= shadow[0];
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  shadow   <= shadow >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shadow[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (byte_idx == last_idx) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 5'd1;
                     state    <= START;
                     tx_q     <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase

         // NOTE: these come after the case so a new request in a packet's start
         // cycle overrides the clear above (last non-blocking write wins).
         if (bus.send_ok) begin
            ok_pend <= 1'b1;
         end
         if (bus.send_signal) begin
            sig_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_debug_reply_tx.sv
// Self-checking bench for debug_reply_tx: a UART monitor decodes the line and
// compares each byte against a queue of expected bytes pushed at request time.
module tb_debug_reply_tx;

   localparam int CPB = 4;
   localparam int SB  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   debug_reply_tx_if #(.SIG_BYTES(SB)) bus ();

   debug_reply_tx #(
      .CLK_PER_BIT(CPB),
      .SIG_BYTES  (SB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];
   int         done_cnt      = 0;
   int         last_done_cyc = 0;

   // Monitor state.
   logic       mon_active = 1'b0;
   int         mon_cnt    = 0;
   int         mon_b      = 0;
   logic       mon_val    = 1'b0;
   logic       mon_glitch = 1'b0;
   logic [7:0] mon_byte   = '0;
   logic [7:0] mon_exp    = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sig(input logic [31:0] p, input logic [31:0] s);
      exp_q.push_back(8'h01);
      for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
      for (int i = 0; i < SB; i++) exp_q.push_back(s[8*i +: 8]);
   endtask

   task automatic check_start(input string tag, input int exp_cyc);
      check({tag, "_present"}, 32'(start_q.size() > 0), 32'd1);
      if (start_q.size() > 0) check(tag, start_q.pop_front(), exp_cyc);
   endtask

   task automatic wait_done(input int target, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (done_cnt >= target) break;
         tick();
      end
      check("done_wait_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   always @(posedge clk) cyc++;

   // Count done pulses and remember when the last one happened.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   // UART decoder: checks every bit is stable for CPB cycles, stop bit high,
   // and each decoded byte against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (bus.uart_tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 1;
            mon_val    = 1'b0;
            mon_glitch = 1'b0;
            start_q.push_back(cyc);
         end
      end else begin
         if (mon_cnt % CPB == 0) mon_val = bus.uart_tx;
         else if (bus.uart_tx !== mon_val) mon_glitch = 1'b1;
         if (mon_cnt % CPB == CPB - 1) begin
            mon_b = mon_cnt / CPB;
            if (mon_b >= 1 && mon_b <= 8) begin
               mon_byte[mon_b-1] = mon_val;
            end else if (mon_b == 9) begin
               check("stop_bit", 32'(mon_val), 32'd1);
               check("bit_stable", 32'(mon_glitch), 32'd0);
               check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  mon_exp = exp_q.pop_front();
                  check("byte", 32'(mon_byte), 32'(mon_exp));
               end
               mon_active = 1'b0;
            end
         end
         mon_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int req;
      int busy_len;
      int d0;

      bus.send_ok     = 1'b0;
      bus.send_signal = 1'b0;
      bus.pc          = '0;
      bus.signals     = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(bus.uart_tx), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      check("idle_tx", 32'(bus.uart_tx), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Single OP_OK: latency, bit timing, busy length, done pulse.
      tick();
      bus.send_ok = 1'b1;
      req = cyc + 1;
      exp_q.push_back(8'h02);
      tick();
      bus.send_ok = 1'b0;
      check("ok_flag_edge_line", {30'd0, bus.uart_tx, bus.busy}, 32'b10);
      tick();
      check("ok_start_line", {30'd0, bus.uart_tx, bus.busy}, 32'b01);
      busy_len = 1;
      for (int i = 0; i < 200 && bus.busy; i++) begin
         tick();
         if (bus.busy) busy_len++;
      end
      check("ok_busy_len", busy_len, 32'd40);
      check("ok_done_cycle", cyc, req + 41);
      check("ok_done_pulse", 32'(bus.done), 32'd1);
      check("ok_done_tx", 32'(bus.uart_tx), 32'd1);
      tick();
      check("ok_done_one_cycle", 32'(bus.done), 32'd0);
      check_start("ok_start", req + 1);
      check("ok_sb_empty", exp_q.size(), 32'd0);

      // OP_SIGNAL contents, back-to-back frames, pc snapshot.
      bus.pc      = 32'h0000_00DC;
      bus.signals = 32'hA55A_0FF0;
      tick();
      bus.send_signal = 1'b1;
      req = cyc + 1;
      push_sig(32'h0000_00DC, 32'hA55A_0FF0);
      tick();
      bus.send_signal = 1'b0;
      tick();
      check("sig_start_line", {30'd0, bus.uart_tx, bus.busy}, 32'b01);
      tick();
      tick();
      bus.pc      = 32'hFFFF_FFFF;
      bus.signals = 32'h0000_0000;
      d0 = done_cnt;
      wait_done(d0 + 1, 1000);
      check("sig_done_cycle", last_done_cyc, req + 361);
      for (int i = 0; i < 9; i++) check_start("sig_frame_start", req + 1 + 40 * i);
      check("sig_sb_empty", exp_q.size(), 32'd0);

      // Simultaneous requests: OK, one idle cycle, SIGNAL.
      bus.pc      = 32'h1234_5678;
      bus.signals = 32'hDEAD_BEEF;
      tick();
      bus.send_ok     = 1'b1;
      bus.send_signal = 1'b1;
      req = cyc + 1;
      exp_q.push_back(8'h02);
      push_sig(32'h1234_5678, 32'hDEAD_BEEF);
      d0 = done_cnt;
      tick();
      bus.send_ok     = 1'b0;
      bus.send_signal = 1'b0;
      wait_done(d0 + 2, 1500);
      check("both_done_cycle", last_done_cyc, req + 402);
      check_start("both_ok_start", req + 1);
      for (int i = 0; i < 9; i++) check_start("both_sig_start", req + 42 + 40 * i);
      repeat (20) tick();
      check("both_done_count", done_cnt, d0 + 2);
      check("both_sb_empty", exp_q.size(), 32'd0);

      // Coalescing: three SIGNAL requests during an OK packet give one packet.
      bus.pc      = 32'hCAFE_F00D;
      bus.signals = 32'h0102_0304;
      tick();
      bus.send_ok = 1'b1;
      req = cyc + 1;
      exp_q.push_back(8'h02);
      push_sig(32'hCAFE_F00D, 32'h0102_0304);
      d0 = done_cnt;
      tick();
      bus.send_ok = 1'b0;
      repeat (5) tick();
      bus.send_signal = 1'b1;
      tick();
      bus.send_signal = 1'b0;
      repeat (3) tick();
      bus.send_signal = 1'b1;
      tick();
      bus.send_signal = 1'b0;
      repeat (10) tick();
      bus.send_signal = 1'b1;
      tick();
      bus.send_signal = 1'b0;
      wait_done(d0 + 2, 1500);
      repeat (300) tick();
      check("coal_done_count", done_cnt, d0 + 2);
      check("coal_busy", 32'(bus.busy), 32'd0);
      check_start("coal_ok_start", req + 1);
      for (int i = 0; i < 9; i++) check_start("coal_sig_start", req + 42 + 40 * i);
      check("coal_no_extra_frame", start_q.size(), 32'd0);
      check("coal_sb_empty", exp_q.size(), 32'd0);

      // Reset mid-frame: async abort, pending packet dropped.
      tick();
      bus.send_signal = 1'b1;
      req = cyc + 1;
      exp_q.push_back(8'h01);
      tick();
      bus.send_signal = 1'b0;
      repeat (50) tick();
      bus.send_ok = 1'b1;
      tick();
      bus.send_ok = 1'b0;
      repeat (9) tick();
      d0 = done_cnt;
      check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
      check("mid_first_byte_seen", exp_q.size(), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(bus.uart_tx), 32'd1);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      start_q.delete();
      repeat (200) tick();
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("post_rst_tx", 32'(bus.uart_tx), 32'd1);
      check("post_rst_no_frame", start_q.size(), 32'd0);
      check("post_rst_no_done", done_cnt, d0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
